field_ser_engine: RTL and testbench
===================================

// Module: field_ser_engine
// PURPOSE
// - Serializes one protobuf field into a downward-growing output buffer in byte-lane DRAM.
// - Combines three functions: a 5-byte field-header (tag) encoder, a varint/fixed encoder,
//   and a DRAM-to-DRAM memcpy engine for string/bytes payloads.
// - Sits under the message aggregator. The aggregator supplies the field descriptor and value;
//   this block returns the new buffer end.
// PARAMETERS
// - LANES     8   DRAM byte lanes per beat (fixed at 8)
// - ADDR_W    64  address width
// PORTS
// - clk            in   1       clock; single clock domain
// - reset          in   1       asynchronous, active-low reset
// - start          in   1       one-cycle request; sampled only while ready=1
// - field_id       in   29      protobuf field number
// - field_type     in   5       descriptor type, 1..18
// - value          in   64      varint/fixed value, or source pointer for types 9/12
// - size           in   32      payload length in bytes (types 9/12 only)
// - end_addr       in   64      one past the last free byte; output is written below this address
// - ready          out  1       idle and able to accept start
// - done           out  1       one-cycle pulse when the field is complete
// - new_end        out  64      end_addr minus total bytes written; valid with done
// - dram_en        out  8       per-lane enable
// - dram_rdwr      out  1       1 = read, 0 = write
// - dram_addr      out  8x64    per-lane byte address
// - dram_data_out  out  8x8     per-lane write data
// - dram_data_in   in   8x8     per-lane read data
// - dram_valid     in   8       per-lane read-data valid; read latency is variable
// BEHAVIOUR
// - Reset: all outputs 0 except ready=1. State returns to IDLE. Any operation in flight is abandoned.
// - Memory layout in ascending address order: header(5) | [length varint] | payload,
//   ending at end_addr-1. Write order is payload, then length, then header.
// - Wire type by field_type:
//   - wt0 (varint): 3,4,5,8,13,14,17,18
//   - wt1 (8-byte LE copy of value): 1,6,16
//   - wt5 (4-byte LE): 2,7,15
//   - wt2 (length-delimited): 9,12
//   - Any other type: no writes; done fires after one cycle and new_end = end_addr.
// - Header: key = {field_id,wt} is emitted as a 5-byte redundant varint.
//   - Bytes 0..3 have bit 7 set; byte 4 has bit 7 clear.
//   - Byte 0 is at the lowest address.
// - Varint encoding:
//   - Little-endian 7-bit groups with minimal length, 1..10 bytes.
//   - int32 (type 5) and enum (type 14) are sign-extended to 64 bits first.
//   - A value of 0 encodes as a single byte 0x00.
//   - Encodings longer than 8 bytes use two write beats: the high-address beat goes first.
// - Memcpy (types 9/12):
//   - Copies size bytes from value..value+size-1 to the bytes just below end_addr.
//   - Works in chunks of up to 8 bytes, highest chunk first.
//   - For each chunk: one read beat, wait until all enabled lanes' dram_valid are high,
//     then one write beat.
//   - The length varint of size is written after the payload.
//   - size=0: no payload beats; length byte 0x00.
// - FSM: IDLE -> PAY_RD -> PAY_WAIT -> PAY_WR -> (PAY_RD while bytes remain)
//        -> LEN_WR -> HDR_WR -> DONE -> IDLE.
//   - Non-copy types go IDLE -> VAL_WR (1-2 beats) -> HDR_WR.
//   - Every write state drives dram_en for exactly one cycle per beat; dram_en=0 otherwise.
// - ready drops the cycle after an accepted start. It rises in the DONE cycle together with done.
// - start while ready=0 is ignored. Inputs are captured at start; later changes have no effect.
// - Address arithmetic is 64-bit modulo. Wrap-around below address 0 is not checked.
// CONFIGURATION
// - SINT_ZIGZAG_EN defined: sint32/sint64 (types 17/18) are zigzag-encoded before the varint.
//   - sint32: (n<<1)^(n>>>31) on 32 bits.
//   - sint64: same on 64 bits.
// - SINT_ZIGZAG_EN undefined: types 17/18 are encoded as plain sign-extended varints.
// TESTING
// - Type 13, id 1, value 150, end 0x300:
//   - 0x2FE..0x2FF = 96 01
//   - 0x2F9..0x2FD = 88 80 80 80 00
//   - new_end = 0x2F9
// - Type 9, id 2, size 3, src holds "abc", dram_valid delayed 5 cycles, end 0x300:
//   - 0x2FD..0x2FF = 61 62 63
//   - 0x2FC = 03
//   - header 92 80 80 80 00 at 0x2F7
//   - new_end = 0x2F7
// - Type 5, value -1: ten bytes FF x9, 01, written in two beats; new_end = end-15.
// - Type 17, value -1:
//   - with SINT_ZIGZAG_EN: payload 01
//   - without: ten-byte encoding
// - Type 7, id 3, value 0x12345678: payload 78 56 34 12; header byte 0 = 0x9D.
// - Reset asserted mid-PAY_WAIT: dram_en=0, ready=1, done=0 immediately.
//   A subsequent start completes normally.

Source files
------------

// File: rtl/field_ser_engine.sv
// field_ser_engine: serializes one protobuf field (tag, value or copied payload)
// downward into byte-lane DRAM and returns the new buffer end.
// Ports: clk, reset (async, active-low); start/field_id/field_type/value/size/
//   end_addr request inputs; ready/done/new_end status; dram_en/dram_rdwr/
//   dram_addr/dram_data_out drive 8 byte lanes, dram_data_in/dram_valid return reads.
// Option: define SINT_ZIGZAG_EN to zigzag-encode sint32/sint64 (types 17/18).
module field_ser_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [28:0]  field_id,
  input  logic [4:0]   field_type,
  input  logic [63:0]  value,
  input  logic [31:0]  size,
  input  logic [63:0]  end_addr,
  output logic         ready,
  output logic         done,
  output logic [63:0]  new_end,
  output logic [7:0]   dram_en,
  output logic         dram_rdwr,
  output logic [511:0] dram_addr,
  output logic [63:0]  dram_data_out,
  input  logic [63:0]  dram_data_in,
  input  logic [7:0]   dram_valid
);

  typedef enum logic [2:0] {
    IDLE, VAL_WR, PAY_RD, PAY_WAIT,
    PAY_WR, LEN_WR, HDR_WR, DONE
  } state_t;

  state_t state_q, state_d;

  logic [63:0] cur_q, src_q, val_q;
  logic [31:0] rem_q, size_q;
  logic [28:0] fid_q;
  logic [2:0]  wt_q;
  logic        beat_q;
  logic [7:0]  got_q;
  logic [63:0] buf_q;

  function automatic logic [3:0] vlen(input logic [63:0] v);
    vlen = 4'd1;
    for (int k = 1; k < 10; k++)
      if ((v >> (7 * k)) != 64'd0) vlen = 4'(k + 1);
  endfunction

  function automatic logic [79:0] venc(input logic [63:0] v);
    logic [69:0] x;
    logic [3:0]  n;
    x = {6'd0, v};
    n = vlen(v);
    venc = '0;
    for (int k = 0; k < 10; k++)
      venc[8*k +: 8] = {(k < int'(n) - 1), x[7*k +: 7]};
  endfunction

  // Request decode: wire type and value after sign-extension / zigzag.
  logic [2:0]  in_wt;
  logic        in_ok;
  logic [63:0] in_val;

  always_comb begin
    in_wt  = 3'd0;
    in_ok  = 1'b1;
    in_val = value;
    unique case (field_type)
      5'd3, 5'd4, 5'd8, 5'd13: in_wt = 3'd0;
      5'd5, 5'd14:
        in_val = {{32{value[31]}}, value[31:0]};
`ifdef SINT_ZIGZAG_EN
      5'd17:
        in_val = {32'd0,
                  {value[30:0], 1'b0} ^ {32{value[31]}}};
      5'd18:
        in_val = {value[62:0], 1'b0} ^ {64{value[63]}};
`else
      5'd17:
        in_val = {{32{value[31]}}, value[31:0]};
      5'd18: in_val = value;
`endif
      5'd1, 5'd6, 5'd16: in_wt = 3'd1;
      5'd2, 5'd7, 5'd15: in_wt = 3'd5;
      5'd9, 5'd12:       in_wt = 3'd2;
      default:           in_ok = 1'b0;
    endcase
  end

  // Memcpy chunk: up to 8 bytes taken from the top of what remains.
  logic [3:0] chunk;
  logic [7:0] cmask;
  assign chunk = (rem_q > 32'd8) ? 4'd8 : rem_q[3:0];
  assign cmask = 8'hFF >> (4'd8 - chunk);

  // Byte source for the three write-from-register states.
  logic [31:0] key;
  logic [79:0] wbytes, wsh;
  logic [3:0]  wn, wcnt, woff;
  logic        two, last_beat;
  logic [63:0] wbase;

  assign key = {fid_q, wt_q};

  always_comb begin
    wbytes = '0;
    wn     = 4'd0;
    unique case (state_q)
      VAL_WR: begin
        if (wt_q == 3'd1) begin
          wbytes = {16'd0, val_q};
          wn     = 4'd8;
        end else if (wt_q == 3'd5) begin
          wbytes = {48'd0, val_q[31:0]};
          wn     = 4'd4;
        end else begin
          wbytes = venc(val_q);
          wn     = vlen(val_q);
        end
      end
      LEN_WR: begin
        wbytes = venc({32'd0, size_q});
        wn     = vlen({32'd0, size_q});
      end
      HDR_WR: begin
        wbytes = {40'd0,
                  4'h0, key[31:28],
                  1'b1, key[27:21],
                  1'b1, key[20:14],
                  1'b1, key[13:7],
                  1'b1, key[6:0]};
        wn     = 4'd5;
      end
      default: ;
    endcase
  end

  // Encodings over 8 bytes: bytes 8.. (high addresses) first.
  assign two       = (wn > 4'd8) && !beat_q;
  assign last_beat = !two;
  assign woff      = two ? 4'd8 : 4'd0;
  assign wcnt      = two ? wn - 4'd8 : wn;
  assign wsh       = wbytes >> {woff, 3'b000};
  assign wbase     = cur_q - {60'd0, wn} + {60'd0, woff};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          if (!in_ok)              state_d = DONE;
          else if (in_wt != 3'd2)  state_d = VAL_WR;
          else if (size == 32'd0)  state_d = LEN_WR;
          else                     state_d = PAY_RD;
        end
      end
      PAY_RD: state_d = PAY_WAIT;
      PAY_WAIT:
        if ((got_q | (dram_valid & cmask)) == cmask)
          state_d = PAY_WR;
      PAY_WR:
        state_d = (rem_q == {28'd0, chunk}) ? LEN_WR : PAY_RD;
      VAL_WR, LEN_WR:
        if (last_beat) state_d = HDR_WR;
      HDR_WR:
        if (last_beat) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready         = (state_q == IDLE) || (state_q == DONE);
    done          = (state_q == DONE);
    new_end       = done ? cur_q : 64'd0;
    dram_en       = '0;
    dram_rdwr     = 1'b0;
    dram_addr     = '0;
    dram_data_out = '0;
    unique case (state_q)
      PAY_RD: begin
        dram_rdwr = 1'b1;
        for (int i = 0; i < 8; i++)
          if (cmask[i]) begin
            dram_en[i]           = 1'b1;
            dram_addr[64*i +: 64] = src_q + {32'd0, rem_q}
                                  - {60'd0, chunk} + 64'(i);
          end
      end
      PAY_WR:
        for (int i = 0; i < 8; i++)
          if (cmask[i]) begin
            dram_en[i]               = 1'b1;
            dram_addr[64*i +: 64]    = cur_q - {60'd0, chunk}
                                     + 64'(i);
            dram_data_out[8*i +: 8]  = buf_q[8*i +: 8];
          end
      VAL_WR, LEN_WR, HDR_WR:
        for (int i = 0; i < 8; i++)
          if (i < int'(wcnt)) begin
            dram_en[i]              = 1'b1;
            dram_addr[64*i +: 64]   = wbase + 64'(i);
            dram_data_out[8*i +: 8] = wsh[8*i +: 8];
          end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      src_q   <= '0;
      val_q   <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      fid_q   <= '0;
      wt_q    <= '0;
      beat_q  <= 1'b0;
      got_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE, DONE:
          if (start) begin
            cur_q  <= end_addr;
            src_q  <= value;
            val_q  <= in_val;
            rem_q  <= size;
            size_q <= size;
            fid_q  <= field_id;
            wt_q   <= in_wt;
            beat_q <= 1'b0;
          end
        PAY_RD: got_q <= '0;
        PAY_WAIT: begin
          got_q <= got_q | (dram_valid & cmask);
          // Lanes may return at different times; hold each first arrival.
          for (int i = 0; i < 8; i++)
            if (dram_valid[i] && cmask[i] && !got_q[i])
              buf_q[8*i +: 8] <= dram_data_in[8*i +: 8];
        end
        PAY_WR: begin
          cur_q <= cur_q - {60'd0, chunk};
          rem_q <= rem_q - {28'd0, chunk};
        end
        VAL_WR, LEN_WR, HDR_WR:
          if (two) beat_q <= 1'b1;
          else begin
            beat_q <= 1'b0;
            cur_q  <= cur_q - {60'd0, wn};
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_field_ser_engine.sv
// tb_field_ser_engine: directed vectors with a scoreboard queue; a DRAM
// model with per-lane staggered read latency and a done-triggered monitor.
module tb_field_ser_engine;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [28:0]  field_id = '0;
  logic [4:0]   field_type = '0;
  logic [63:0]  value = '0;
  logic [31:0]  size = '0;
  logic [63:0]  end_addr = '0;
  logic         ready, done;
  logic [63:0]  new_end;
  logic [7:0]   dram_en;
  logic         dram_rdwr;
  logic [511:0] dram_addr;
  logic [63:0]  dram_data_out;
  logic [63:0]  dram_data_in;
  logic [7:0]   dram_valid;

  always #5 clk = ~clk;

  field_ser_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .field_id(field_id), .field_type(field_type),
    .value(value), .size(size), .end_addr(end_addr),
    .ready(ready), .done(done), .new_end(new_end),
    .dram_en(dram_en), .dram_rdwr(dram_rdwr),
    .dram_addr(dram_addr), .dram_data_out(dram_data_out),
    .dram_data_in(dram_data_in), .dram_valid(dram_valid)
  );

  logic [7:0]  mem [0:4095];
  int          rd_delay = 5;
  int          cntl [8];
  logic [63:0] paddr [8];
  int          total = 0;
  int          bad = 0;
  int          wbeats = 0;

  typedef struct {
    logic [63:0]  ne;
    int           n;
    int           beats;
    logic [255:0] b;
  } exp_t;

  exp_t q[$];
  exp_t e;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // DRAM: writes land at the edge; reads return per lane after a delay
  // (odd lanes one cycle later) as a single-cycle valid pulse.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) cntl[i] <= 0;
      dram_valid   <= '0;
      dram_data_in <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        dram_valid[i] <= 1'b0;
        if (cntl[i] == 1) begin
          dram_valid[i] <= 1'b1;
          dram_data_in[8*i +: 8] <= mem[paddr[i][11:0]];
          cntl[i] <= 0;
        end else if (cntl[i] > 1) begin
          cntl[i] <= cntl[i] - 1;
        end
        if (dram_en[i]) begin
          if (dram_rdwr) begin
            cntl[i]  <= rd_delay + (i % 2);
            paddr[i] <= dram_addr[64*i +: 64];
          end else begin
            mem[dram_addr[64*i +: 12]] <= dram_data_out[8*i +: 8];
          end
        end
      end
    end
  end

  // Monitor: counts write beats, checks each completed field.
  always @(negedge clk) begin
    if (!reset) begin
      wbeats = 0;
    end else begin
      if (dram_en != 8'd0 && !dram_rdwr) wbeats++;
      if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: new_end %h", new_end);
        end else begin
          logic        ok;
          logic [7:0]  want, got;
          logic [63:0] a;
          e = q.pop_front();
          chk("new_end", new_end, e.ne);
          chk("write_beats", 64'(wbeats), 64'(e.beats));
          ok = 1'b1;
          for (int k = -1; k <= e.n; k++) begin
            a    = e.ne + 64'(k);
            got  = mem[a[11:0]];
            want = (k < 0 || k >= e.n) ? 8'hEE
                 : e.b[8*(e.n-1-k) +: 8];
            if (got !== want) begin
              ok = 1'b0;
              $display("FAIL mem_bytes @%h: got %h want %h",
                       a, got, want);
            end
          end
          total++;
          if (!ok) bad++;
          wbeats = 0;
        end
      end
    end
  end

  task automatic expect_op(input logic [63:0] ne, input int n,
                           input int beats, input logic [255:0] b);
    exp_t x;
    x.ne = ne; x.n = n; x.beats = beats; x.b = b;
    q.push_back(x);
  endtask

  function automatic bit type_ok(input logic [4:0] t);
    return (t >= 5'd1 && t <= 5'd18 && t != 5'd10 && t != 5'd11);
  endfunction

  task automatic op(input logic [4:0] t, input logic [28:0] id,
                    input logic [63:0] v, input logic [31:0] sz,
                    input logic [63:0] ea);
    int guard = 0;
    while (!ready) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: ready %b want 1", ready);
        return;
      end
    end
    field_type = t; field_id = id; value = v;
    size = sz; end_addr = ea; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    field_type = 5'd13; field_id = '1; value = '1;
    size = '1; end_addr = '0;
    chk("ready_after_start", 64'(ready), type_ok(t) ? 64'd0 : 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    mem[12'h100] = 8'h61; mem[12'h101] = 8'h62; mem[12'h102] = 8'h63;
    for (int k = 0; k < 11; k++) mem[12'h200 + k] = 8'(8'h10 + k);

    #12;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_en", 64'(dram_en), 64'd0);
    chk("rst_new_end", new_end, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    expect_op(64'h2F9, 7, 2, 56'h88808080009601);
    op(5'd13, 29'd1, 64'd150, 32'd0, 64'h300);

    expect_op(64'h2F7, 9, 3, 72'h928080800003616263);
    op(5'd9, 29'd2, 64'h100, 32'd3, 64'h300);
    repeat (3) @(posedge clk);
    #1 field_type = 5'd13; end_addr = 64'h700; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;

    expect_op(64'h3F1, 15, 3,
              120'h8880808000FFFFFFFFFFFFFFFFFF01);
    op(5'd5, 29'd1, 64'h0000_0000_FFFF_FFFF, 32'd0, 64'h400);

`ifdef SINT_ZIGZAG_EN
    expect_op(64'h4FA, 6, 2, 48'h888080800001);
`else
    expect_op(64'h4F1, 15, 3,
              120'h8880808000FFFFFFFFFFFFFFFFFF01);
`endif
    op(5'd17, 29'd1, 64'h0000_0000_FFFF_FFFF, 32'd0, 64'h500);

    expect_op(64'h5F7, 9, 2, 72'h9D8080800078563412);
    op(5'd7, 29'd3, 64'h12345678, 32'd0, 64'h600);

    expect_op(64'h6F3, 13, 2, 104'hA9808080000807060504030201);
    op(5'd1, 29'd5, 64'h0102030405060708, 32'd0, 64'h700);

    expect_op(64'h800, 0, 0, 256'd0);
    op(5'd10, 29'd1, 64'd5, 32'd0, 64'h800);

    expect_op(64'h8FA, 6, 2, 48'hA28080800000);
    op(5'd9, 29'd4, 64'h100, 32'd0, 64'h900);

    expect_op(64'h9EF, 17, 4,
              136'h8A808080000B101112131415161718191A);
    op(5'd12, 29'd1, 64'h200, 32'd11, 64'hA00);

    expect_op(64'hAFA, 6, 2, 48'hF8FFFFFF0F00);
    op(5'd13, 29'h1FFFFFFF, 64'd0, 32'd0, 64'hB00);

    expect_op(64'hBF9, 7, 2, 56'h8880808000AC02);
    op(5'd3, 29'd1, 64'd300, 32'd0, 64'hC00);

    // Abort a copy while it waits on read data.
    rd_delay = 20;
    op(5'd9, 29'd1, 64'h100, 32'd5, 64'hD00);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_en", 64'(dram_en), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    rd_delay = 3;

    expect_op(64'hDF9, 7, 2, 56'h88808080009601);
    op(5'd13, 29'd1, 64'd150, 32'd0, 64'hE00);

    for (int g = 0; g < 2000 && q.size() != 0; g++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending %0d want 0", q.size());
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
